// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W_DEF  = 4;

  // Bit positions inside rsp_flags = {carry, sign, zero}
  localparam int FLAG_CF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_ZF = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_grant.sv
// Grant selection between two requesters; only asserts a grant while idle.
// Latency: combinational.
// Backpressure: none here; the caller gates with idle_i.
module alu_arbiter_grant (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  logic       idle_i,
  output logic [1:0] grant_o
);

  // On contention the requester not granted last wins; a tied-high last_grant_i
  // turns this into fixed priority for requester 0. A lone requester always wins.
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = idle_i & valid0_i & (~valid1_i | last_grant_i);
    grant_o[1] = idle_i & valid1_i & (~valid0_i | ~last_grant_i);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU; ALU_ARBITER_RR_EN selects round-robin, else fixed priority (req0).
// Latency: transfer in cycle N -> rsp_valid in cycle N+2; one operation per 3 cycles at best.
// Backpressure: response held stable until rsp_ready; no new request accepted until the handshake completes.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       grant;
  logic             last_grant;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             id_q, id_d;
  logic [2:0]       flags_q, flags_d;

  alu_arbiter_grant u_grant (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant),
    .idle_i       (state_q == S_IDLE),
    .grant_o      (grant)
  );

`ifdef ALU_ARBITER_RR_EN
  logic last_q, last_d;

  // Remember which requester was granted most recently.
  always_comb begin
    last_d = last_q;
    if (grant[0])      last_d = 1'b0;
    else if (grant[1]) last_d = 1'b1;
  end

  // Last-grant register; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_grant = last_q;
`else
  // Constant "last was 1" makes the grant logic favour requester 0 every time.
  assign last_grant = 1'b1;
`endif

  // Next-state: one cycle of execution, then hold the response until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|grant) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-values: capture the granted request, then the ALU output at end of EXEC.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (grant[0]) begin
      a_d  = req0_a;
      b_d  = req0_b;
      op_d = req0_op;
      id_d = 1'b0;
    end else if (grant[1]) begin
      a_d  = req1_a;
      b_d  = req1_b;
      op_d = req1_op;
      id_d = 1'b1;
    end
    if (state_q == S_EXEC) begin
      res_d            = alu_result;
      flags_d[FLAG_CF] = alu_cf;
      flags_d[FLAG_SF] = alu_sf;
      flags_d[FLAG_ZF] = alu_zf;
    end
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an ADD/SUB ALU model; honours ALU_ARBITER_RR_EN for contention expectations.
// Latency: checks response at transfer+2.
// Backpressure: holds rsp_ready low for several cycles in one scenario.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_cf, alu_sf, alu_zf;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // ALU model: op 0 = ADD (carry out), op 1 = SUB (carry = borrow).
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = 33'd0;
    if (alu_op == 4'h0)      alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == 4'h1) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
    alu_result = alu_wide[31:0];
    alu_cf     = alu_wide[32];
    alu_sf     = alu_wide[31];
    alu_zf     = (alu_wide[31:0] == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  // One uncontended operation with an immediate response handshake.
  task automatic single_op(input string tag, input logic id, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] er, input logic [2:0] ef);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    chk({tag, "_rdy0"}, req0_ready, !id);
    chk({tag, "_rdy1"}, req1_ready, id);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rspv"}, rsp_valid, 0);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_op"}, alu_op, op);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_rspv"}, rsp_valid, 1);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_flags"}, rsp_flags, ef);
    chk({tag, "_id"}, rsp_id, id);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rspv"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:3] exp_ids;
    int got;
    int spurious;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_id", rsp_id, 0);
    rst_n = 1'b1;

    single_op("add", 1'b0, 32'h5, 32'h3, 4'h0, 32'h8, 3'b000);
    single_op("carry", 1'b1, 32'hFFFF_FFFF, 32'h1, 4'h0, 32'h0, 3'b101);

    // Backpressure: response held for 5 cycles while req1 waits.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd10; req0_op = 4'h1;
    #1 chk("bp_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 4'h1;
    #1 chk("bp_exec_rdy1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d_rspv", i), rsp_valid, 1);
      chk($sformatf("bp%0d_res", i), rsp_result, 32'hFFFF_FFF9);
      chk($sformatf("bp%0d_flags", i), rsp_flags, 3'b110);
      chk($sformatf("bp%0d_id", i), rsp_id, 0);
      chk($sformatf("bp%0d_rdys", i), {req0_ready, req1_ready}, 2'b00);
      chk($sformatf("bp%0d_busy", i), busy, 1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_rspv", rsp_valid, 1);
    chk("bp_hs_rdy1", req1_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_next_rdy1", req1_ready, 1);
    chk("bp_next_busy", busy, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 chk("bp2_alu_a", alu_a, 32'd2);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp2_res", rsp_result, 32'd0);
    chk("bp2_flags", rsp_flags, 3'b001);
    chk("bp2_id", rsp_id, 1);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Contention: both requesters valid for four operations.
`ifdef ALU_ARBITER_RR_EN
    exp_ids = 4'b0101;
`else
    exp_ids = 4'b0000;
`endif
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'h0;
    req1_a = 32'd7; req1_b = 32'd2; req1_op = 4'h1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin
        chk($sformatf("cont%0d_id", got), rsp_id, exp_ids[got]);
        chk($sformatf("cont%0d_res", got), rsp_result, exp_ids[got] ? 32'd5 : 32'd2);
        got++;
        if (got == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
    end
    chk("cont_count", got, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("cont_idle", busy, 0);

    // Mid-op reset in EXEC.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h55; req0_b = 32'h1; req0_op = 4'h0;
    #1 chk("mr_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("mr_exec_alu_a", alu_a, 32'h55);
    chk("mr_exec_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("mr_rspv", rsp_valid, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_busy", busy, 0);
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) spurious++;
    end
    chk("mr_no_rsp", spurious, 0);
    rsp_ready = 1'b0;

    // First contention after reset goes to requester 0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd6; req0_op = 4'h0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd1; req1_op = 4'h1;
    #1 chk("post_rst_rdys", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_res", rsp_result, 32'd10);
    @(negedge clk);
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
